alu_instr_sequencer: RTL and testbench
======================================

# alu_instr_sequencer

Program sequencer that sits in front of the 16-bit-instruction ALU/register-file processor and drives its instruction pins. It accepts a short program as a byte stream, then on command issues each instruction for a fixed number of cycles. It captures the processor's 8-bit result and zero flag for each instruction into a result buffer, which the host drains afterwards. It is the issuing end of the processor's instruction/result pin interface.

## Interface
- DEPTH, 8: number of program/result slots; power of 2, at least 2.
- HOLD, 2: cycles each instruction is held on instr_out; at least 1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_wr_en  in  1  program byte strobe.
- cfg_wr_data  in  8  program byte; low byte of each instruction is sent first.
- clr  in  1  pulse; clears the program and the result buffer.
- start  in  1  pulse; begins a run.
- instr_out  out  16  instruction to processor; [7:0] drives ui_in, [15:8] drives uio_in.
- instr_valid  out  1  instr_out carries a program slot.
- res_in  in  8  processor result (uo_out).
- zero_in  in  1  processor zero flag (uio_out[0]).
- res_rd_en  in  1  pop one result.
- res_rd_data  out  9  {zero, result[7:0]}.
- res_rd_valid  out  1  res_rd_data valid; one-cycle pulse.
- prog_count  out  clog2(DEPTH)+1  complete instructions loaded.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE, loading:**
  - A byte toggle selects low/high half. The high byte completes slot[prog_count] and increments prog_count.
  - Writes are ignored once prog_count == DEPTH (full).
- **start in IDLE or DONE:**
  - Clears the half-byte toggle, which discards any pending low byte.
  - Resets the slot and hold counters and the result write/read pointers, then enters RUN.
  - If prog_count == 0, goes directly to DONE with no results.
- **RUN:**
  - Drives slot[i] with instr_valid=1 for HOLD cycles.
  - On the last hold cycle, registers {zero_in, res_in} into result[i].
  - After slot prog_count-1, enters DONE. instr_out then returns to 16'h0000, which is opcode 000 (no register write), with instr_valid=0.
- **DONE:**
  - res_rd_en returns results in slot order.
  - Reading past the last result gives res_rd_valid=0.
  - The program is retained, so start reruns it.
- **Inputs that are ignored or have priority:**
  - In RUN: cfg_wr_en, start, clr and res_rd_en are ignored.
  - Same cycle in IDLE/DONE: start has priority over cfg_wr_en; the byte is dropped.
  - In IDLE/DONE, clr has priority over start and cfg_wr_en. It sets prog_count=0, clears the toggle and pointers, and goes to IDLE.
  - cfg_wr_en in DONE is ignored.
- **Width rules:** slot index wraps modulo DEPTH and never exceeds prog_count-1. The hold counter counts 0..HOLD-1.

## Timing
- **Reset values:** instr_out=0, instr_valid=0, res_rd_data=0, res_rd_valid=0, prog_count=0, busy=0, done=0. Slot and result contents are don't-care.
- All outputs are registered.
- **Run start:** start is sampled at edge T. instr_out=slot0 and busy=1 from T+1.
- **Instruction cadence:** slot k is held over cycles T+1+k·HOLD … T+k·HOLD+HOLD. res_in is sampled at the edge that ends that window.
- **End of run:** the FSM enters DONE, and done=1, one cycle after the last window ends. Total busy cycles = prog_count·HOLD.
- **Empty program:** start with prog_count=0 gives done=1 at T+1.
- **Result read:** res_rd_en sampled at edge R gives res_rd_valid=1 with data during R+1. Back-to-back reads are supported.
- **Reset mid-run:** asynchronous return to IDLE with reset values. The program is lost.

## Structure
- **Shared package:**
  - FSM state enum.
  - Processor field constants: OPC [2:0], FUNC [6:3], REG2 [9:7], REG1 [12:10], REGW [15:13].
  - OPC_REGWRITE=3'b011, INSTR_NOP=16'h0000.
  - Default DEPTH and HOLD.
- **Sub-module seq_slot_mem:** parameterised register array with one write port and one registered read port. It is instantiated twice: program memory at 16 bits wide and result memory at 9 bits wide.

## Test plan
- **Load, run, read back:** write bytes 33,05, 13,0D, 3B,94 with HOLD=2. Bench model drives res_in = instr_out[7:0]^instr_out[15:8]. Required response:
  - prog_count=3.
  - instr_out sequence 0533, 0D13, 943B, each held 2 cycles.
  - busy=6 cycles.
  - Reads return 036, 01E, 0AF.
- **Zero flag:** bench drives res_in=00 and zero_in=1 for slot 1. Read 1 returns 9'h100; the other reads have zero bit 0.
- **Full:** write 2·DEPTH+2 bytes. prog_count stays at DEPTH, and the extra instruction never appears on instr_out.
- **Odd byte and start collision:**
  - Write 1 byte, then start. The partial instruction is discarded.
  - Start and cfg_wr_en in the same cycle: the byte is dropped and the run begins.
- **Empty and rerun:**
  - start with prog_count=0 gives done at T+1 and res_rd_valid never asserts.
  - start in DONE reruns an identical sequence.
- **Reset and clear:**
  - rst_n low mid-RUN: all outputs zero immediately, prog_count=0.
  - clr in DONE gives IDLE and prog_count=0.

Source files
------------

// File: rtl/alu_instr_sequencer_pkg.sv
// Shared types and processor instruction-field constants for the ALU program sequencer.
// Field positions describe the 16-bit instruction word driven onto ui_in/uio_in.
package alu_instr_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int OPC_LSB  = 0;
    localparam int OPC_MSB  = 2;
    localparam int FUNC_LSB = 3;
    localparam int FUNC_MSB = 6;
    localparam int REG2_LSB = 7;
    localparam int REG2_MSB = 9;
    localparam int REG1_LSB = 10;
    localparam int REG1_MSB = 12;
    localparam int REGW_LSB = 13;
    localparam int REGW_MSB = 15;

    localparam logic [2:0]  OPC_REGWRITE = 3'b011;
    localparam logic [15:0] INSTR_NOP    = 16'h0000;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_HOLD  = 2;

endpackage

// File: rtl/alu_instr_sequencer_seq_slot_mem.sv
// Slot store: register array with one write port and one registered read port.
// Read data appears one cycle after rd_en and falls back to IDLE_VAL when rd_en is low.
module seq_slot_mem #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 8,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the owner tracks which slots are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= IDLE_VAL;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= IDLE_VAL;
        end
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Loads a byte-stream program, issues each instruction for HOLD cycles and captures results.
// instr_out follows start by one cycle; results are read back one cycle after res_rd_en.
module alu_instr_sequencer
    import alu_instr_sequencer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int HOLD  = DEFAULT_HOLD
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_wr_en,
    input  logic [7:0]                 cfg_wr_data,
    input  logic                       clr,
    input  logic                       start,
    output logic [15:0]                instr_out,
    output logic                       instr_valid,
    input  logic [7:0]                 res_in,
    input  logic                       zero_in,
    input  logic                       res_rd_en,
    output logic [8:0]                 res_rd_data,
    output logic                       res_rd_valid,
    output logic [$clog2(DEPTH):0]     prog_count,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);

    state_t          state;
    logic [AW-1:0]   slot;
    logic [HW-1:0]   hold_cnt;
    logic            byte_hi;
    logic [7:0]      low_byte;
    logic [CW-1:0]   res_count;
    logic [CW-1:0]   rd_ptr;

    logic            ctl_ok;
    logic            do_clr;
    logic            do_start;
    logic            do_load;
    logic            prog_we;
    logic            last_hold;
    logic            last_slot;
    logic            issue;
    logic [AW-1:0]   issue_addr;
    logic            do_read;

    always_comb begin
        ctl_ok    = (state != ST_RUN);
        do_clr    = ctl_ok && clr;
        do_start  = ctl_ok && !clr && start;
        do_load   = (state == ST_IDLE) && !clr && !start && cfg_wr_en && (prog_count != FULL);
        prog_we   = do_load && byte_hi;
        last_hold = (state == ST_RUN) && (hold_cnt == HOLD_LAST);
        last_slot = ({1'b0, slot} == (prog_count - CW'(1)));
        do_read   = (state == ST_DONE) && !clr && !start && res_rd_en && (rd_ptr < res_count);

        // Select the slot that must be on instr_out next cycle, since the read port is registered.
        issue      = 1'b0;
        issue_addr = slot;
        if (do_start && (prog_count != '0)) begin
            issue      = 1'b1;
            issue_addr = '0;
        end else if (state == ST_RUN) begin
            if (!last_hold) begin
                issue      = 1'b1;
                issue_addr = slot;
            end else if (!last_slot) begin
                issue      = 1'b1;
                issue_addr = slot + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            slot         <= '0;
            hold_cnt     <= '0;
            byte_hi      <= 1'b0;
            low_byte     <= '0;
            res_count    <= '0;
            rd_ptr       <= '0;
            prog_count   <= '0;
            instr_valid  <= 1'b0;
            res_rd_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            instr_valid  <= issue;
            res_rd_valid <= do_read;
            if (do_clr) begin
                state      <= ST_IDLE;
                prog_count <= '0;
                byte_hi    <= 1'b0;
                slot       <= '0;
                hold_cnt   <= '0;
                res_count  <= '0;
                rd_ptr     <= '0;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else if (do_start) begin
                byte_hi   <= 1'b0;
                slot      <= '0;
                hold_cnt  <= '0;
                res_count <= '0;
                rd_ptr    <= '0;
                if (prog_count == '0) begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= ST_RUN;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (do_load) begin
                            if (byte_hi) begin
                                prog_count <= prog_count + CW'(1);
                                byte_hi    <= 1'b0;
                            end else begin
                                low_byte <= cfg_wr_data;
                                byte_hi  <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (last_hold) begin
                            hold_cnt  <= '0;
                            res_count <= res_count + CW'(1);
                            if (last_slot) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                slot <= slot + AW'(1);
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    ST_DONE: begin
                        if (do_read) begin
                            rd_ptr <= rd_ptr + CW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    seq_slot_mem #(
        .WIDTH    (16),
        .DEPTH    (DEPTH),
        .IDLE_VAL (INSTR_NOP)
    ) u_prog_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (prog_we),
        .wr_addr (prog_count[AW-1:0]),
        .wr_data ({cfg_wr_data, low_byte}),
        .rd_en   (issue),
        .rd_addr (issue_addr),
        .rd_data (instr_out)
    );

    seq_slot_mem #(
        .WIDTH    (9),
        .DEPTH    (DEPTH),
        .IDLE_VAL (9'h000)
    ) u_res_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (last_hold),
        .wr_addr (slot),
        .wr_data ({zero_in, res_in}),
        .rd_en   (do_read),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (res_rd_data)
    );

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed and randomized bench for alu_instr_sequencer against a queue-based program/result model.
module tb_alu_instr_sequencer;
    import alu_instr_sequencer_pkg::*;

    localparam int DEPTH = 8;
    localparam int HOLD  = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_wr_en = 1'b0;
    logic [7:0]    cfg_wr_data = '0;
    logic          clr = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   instr_out;
    logic          instr_valid;
    logic [7:0]    res_in = '0;
    logic          zero_in = 1'b0;
    logic          res_rd_en = 1'b0;
    logic [8:0]    res_rd_data;
    logic          res_rd_valid;
    logic [CW-1:0] prog_count;
    logic          busy;
    logic          done;

    int compared   = 0;
    int mismatched = 0;

    // Model: loaded program, pending low byte, whether loads are accepted, expected results.
    logic [15:0] m_prog[$];
    logic [8:0]  m_res[$];
    logic        m_pend = 1'b0;
    logic [7:0]  m_low = '0;
    logic        m_idle = 1'b1;
    logic [7:0]  plan_res[DEPTH];
    logic        plan_z[DEPTH];

    always #5 clk = ~clk;

    alu_instr_sequencer #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_data  (cfg_wr_data),
        .clr          (clr),
        .start        (start),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .res_in       (res_in),
        .zero_in      (zero_in),
        .res_rd_en    (res_rd_en),
        .res_rd_data  (res_rd_data),
        .res_rd_valid (res_rd_valid),
        .prog_count   (prog_count),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] make_instr(input logic [2:0] regw, input logic [2:0] reg1,
                                               input logic [2:0] reg2, input logic [3:0] func,
                                               input logic [2:0] opc);
        logic [15:0] v;
        v = INSTR_NOP;
        v[REGW_MSB:REGW_LSB] = regw;
        v[REG1_MSB:REG1_LSB] = reg1;
        v[REG2_MSB:REG2_LSB] = reg2;
        v[FUNC_MSB:FUNC_LSB] = func;
        v[OPC_MSB:OPC_LSB]   = opc;
        return v;
    endfunction

    task automatic wr_byte(input logic [7:0] b);
        cfg_wr_en   = 1'b1;
        cfg_wr_data = b;
        tick();
        cfg_wr_en = 1'b0;
        if (m_idle && m_prog.size() < DEPTH) begin
            if (!m_pend) begin
                m_low  = b;
                m_pend = 1'b1;
            end else begin
                m_prog.push_back({b, m_low});
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_prog.delete();
        m_res.delete();
        m_pend = 1'b0;
        m_idle = 1'b1;
        chk("clr_prog_count", 32'(prog_count), 0);
        chk("clr_done", 32'(done), 0);
        chk("clr_busy", 32'(busy), 0);
    endtask

    task automatic xor_plan();
        for (int k = 0; k < DEPTH; k++) begin
            if (k < m_prog.size()) plan_res[k] = m_prog[k][7:0] ^ m_prog[k][15:8];
            else plan_res[k] = '0;
            plan_z[k] = 1'b0;
        end
    endtask

    task automatic rand_plan();
        for (int k = 0; k < DEPTH; k++) begin
            plan_res[k] = 8'($urandom);
            plan_z[k]   = 1'($urandom);
        end
    endtask

    // Pulses start (optionally colliding with a byte write), checks every issue cycle and the end of run.
    task automatic run_prog(input string tag, input bit collide);
        int n;
        int busy_cycles;
        n = m_prog.size();
        busy_cycles = 0;
        chk({tag, "_pre_busy"}, 32'(busy), 0);
        start = 1'b1;
        if (collide) begin
            cfg_wr_en   = 1'b1;
            cfg_wr_data = 8'($urandom);
        end
        tick();
        start     = 1'b0;
        cfg_wr_en = 1'b0;
        m_pend    = 1'b0;
        m_idle    = 1'b0;
        m_res.delete();
        if (n == 0) begin
            chk({tag, "_empty_done"}, 32'(done), 1);
            chk({tag, "_empty_busy"}, 32'(busy), 0);
            chk({tag, "_empty_valid"}, 32'(instr_valid), 0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            for (int h = 0; h < HOLD; h++) begin
                res_in  = plan_res[k];
                zero_in = plan_z[k];
                chk({tag, "_instr"}, 32'(instr_out), 32'(m_prog[k]));
                chk({tag, "_ivalid"}, 32'(instr_valid), 1);
                chk({tag, "_done_in_run"}, 32'(done), 0);
                if (busy) busy_cycles++;
                tick();
            end
            m_res.push_back({plan_z[k], plan_res[k]});
        end
        res_in  = '0;
        zero_in = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(n * HOLD));
        chk({tag, "_end_done"}, 32'(done), 1);
        chk({tag, "_end_busy"}, 32'(busy), 0);
        chk({tag, "_end_ivalid"}, 32'(instr_valid), 0);
        chk({tag, "_end_instr"}, 32'(instr_out), 32'(INSTR_NOP));
    endtask

    // Back-to-back reads of every result plus one read past the end.
    task automatic read_all(input string tag);
        int n;
        n = m_res.size();
        res_rd_en = 1'b1;
        for (int i = 0; i <= n; i++) begin
            tick();
            if (i < n) begin
                chk({tag, "_rd_valid"}, 32'(res_rd_valid), 1);
                chk({tag, "_rd_data"}, 32'(res_rd_data), 32'(m_res[i]));
            end else begin
                chk({tag, "_rd_past_end"}, 32'(res_rd_valid), 0);
            end
        end
        res_rd_en = 1'b0;
        tick();
        chk({tag, "_rd_idle"}, 32'(res_rd_valid), 0);
    endtask

    task automatic load_random(input int n);
        logic [15:0] ins;
        for (int k = 0; k < n; k++) begin
            ins = make_instr(3'($urandom), 3'($urandom), 3'($urandom), 4'($urandom),
                             ($urandom_range(0, 1) == 1) ? OPC_REGWRITE : 3'($urandom));
            wr_byte(ins[7:0]);
            wr_byte(ins[15:8]);
        end
    endtask

    initial begin
        logic [7:0] prog_bytes [6];
        prog_bytes = '{8'h33, 8'h05, 8'h13, 8'h0D, 8'h3B, 8'h94};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr_out", 32'(instr_out), 0);
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_res_rd_data", 32'(res_rd_data), 0);
        chk("rst_res_rd_valid", 32'(res_rd_valid), 0);
        chk("rst_prog_count", 32'(prog_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        tick();

        // Load, run, read back the reference program
        foreach (prog_bytes[i]) wr_byte(prog_bytes[i]);
        chk("basic_prog_count", 32'(prog_count), 3);
        chk("basic_model_slot2", 32'(m_prog[2]), 32'h943B);
        xor_plan();
        run_prog("basic", 1'b0);
        read_all("basic");

        // Rerun from DONE, then rerun with the zero flag forced on slot 1
        run_prog("rerun", 1'b0);
        read_all("rerun");
        plan_res[1] = 8'h00;
        plan_z[1]   = 1'b1;
        run_prog("zero", 1'b0);
        read_all("zero");
        chk("zero_slot1_expect", 32'(m_res[1]), 32'h100);

        // Writes in DONE are ignored
        wr_byte(8'hAA);
        wr_byte(8'h55);
        chk("done_wr_ignored", 32'(prog_count), 3);

        // Full program: extra instruction must never issue
        do_clr();
        for (int i = 0; i < 2 * DEPTH + 2; i++) wr_byte(8'($urandom));
        chk("full_prog_count", 32'(prog_count), DEPTH);
        rand_plan();
        run_prog("full", 1'b0);
        read_all("full");

        // Pending odd byte plus a write colliding with start
        do_clr();
        for (int i = 0; i < 5; i++) wr_byte(8'($urandom));
        chk("odd_prog_count", 32'(prog_count), 2);
        rand_plan();
        run_prog("collide", 1'b1);
        chk("collide_prog_count", 32'(prog_count), 2);
        read_all("collide");

        // Empty program
        do_clr();
        run_prog("empty", 1'b0);
        read_all("empty");

        // Randomized programs
        for (int it = 0; it < 4; it++) begin
            do_clr();
            load_random($urandom_range(1, DEPTH));
            if ($urandom_range(0, 1) == 1) wr_byte(8'($urandom));
            chk("rand_prog_count", 32'(prog_count), 32'(m_prog.size()));
            rand_plan();
            run_prog("rand", 1'b0);
            read_all("rand");
        end

        // clr in DONE returns to IDLE with an empty program
        chk("pre_clr_done", 32'(done), 1);
        do_clr();

        // Asynchronous reset in the middle of a run
        load_random(3);
        xor_plan();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("midrun_busy_before_rst", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_instr_out", 32'(instr_out), 0);
        chk("arst_instr_valid", 32'(instr_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_prog_count", 32'(prog_count), 0);
        chk("arst_res_rd_valid", 32'(res_rd_valid), 0);
        chk("arst_res_rd_data", 32'(res_rd_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_prog.delete();
        m_res.delete();
        m_pend = 1'b0;
        m_idle = 1'b1;
        tick();
        chk("post_rst_prog_count", 32'(prog_count), 0);
        run_prog("post_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit expired");
    end

endmodule
